// File: rtl/disp_sword_pkg.sv
// Shared constants and frame state encoding for the SWORD serial display driver.
package disp_sword_pkg;

  localparam int SEG_BITS = 64;
  localparam int LED_BITS = 16;
  localparam int DIGITS   = 8;

  // Active-low segment patterns {dp,g,f,e,d,c,b,a} with the dp bit left off (high).
  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4
  } disp_state_e;

endpackage

// File: rtl/disp_hex2seg.sv
// Combinational hex nibble to 7-bit active-low segment pattern {g,f,e,d,c,b,a}.
module disp_hex2seg
  import disp_sword_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // lookup of the per-digit glyph
  always_comb begin
    pattern = 7'h7F;
    case (nibble)
      4'h0:    pattern = SEG_HEX_0[6:0];
      4'h1:    pattern = SEG_HEX_1[6:0];
      4'h2:    pattern = SEG_HEX_2[6:0];
      4'h3:    pattern = SEG_HEX_3[6:0];
      4'h4:    pattern = SEG_HEX_4[6:0];
      4'h5:    pattern = SEG_HEX_5[6:0];
      4'h6:    pattern = SEG_HEX_6[6:0];
      4'h7:    pattern = SEG_HEX_7[6:0];
      4'h8:    pattern = SEG_HEX_8[6:0];
      4'h9:    pattern = SEG_HEX_9[6:0];
      4'hA:    pattern = SEG_HEX_A[6:0];
      4'hB:    pattern = SEG_HEX_B[6:0];
      4'hC:    pattern = SEG_HEX_C[6:0];
      4'hD:    pattern = SEG_HEX_D[6:0];
      4'hE:    pattern = SEG_HEX_E[6:0];
      4'hF:    pattern = SEG_HEX_F[6:0];
      default: pattern = 7'h7F;
    endcase
  end

endmodule

// File: rtl/board_disp_shift_sword.sv
// Serialises the board LED word and 7-segment image onto the SWORD shift-register chains.
// Optional periodic resend is enabled by defining DISP_AUTO_REFRESH_EN.
module board_disp_shift_sword
  import disp_sword_pkg::*;
#(
  parameter int CLK_FREQ   = 100,
  parameter int SHIFT_FREQ = 1,
  parameter int REFRESH_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en,
  input  logic        mode,
  input  logic [31:0] data_text,
  input  logic [63:0] data_graphic,
  input  logic [7:0]  dot,
  input  logic [15:0] led,
  output logic        led_clk,
  output logic        seg_clk,
  output logic        led_do,
  output logic        seg_do,
  output logic        led_en,
  output logic        seg_en,
  output logic        led_clr_n,
  output logic        seg_clr_n
);

  localparam int HALF   = CLK_FREQ / (2 * SHIFT_FREQ);
  localparam int PERIOD = 2 * HALF;
  localparam int PH_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int BIT_W  = $clog2(SEG_BITS);
  localparam int IN_W   = DIGITS + 1 + 32 + SEG_BITS + DIGITS + LED_BITS;

  if (HALF < 1) begin : g_bad_half
    $error("board_disp_shift_sword: CLK_FREQ/(2*SHIFT_FREQ) must be at least 1");
  end
  if (REFRESH_MS < 1) begin : g_bad_refresh
    $error("board_disp_shift_sword: REFRESH_MS must be at least 1");
  end

  disp_state_e         state_r, state_nxt_s;
  logic [PH_W-1:0]     phase_r, phase_nxt_s;
  logic [BIT_W-1:0]    bit_r, bit_nxt_s;
  logic [SEG_BITS-1:0] seg_sh_r;
  logic [LED_BITS-1:0] led_sh_r;
  logic [SEG_BITS-1:0] seg_img_s;
  logic [IN_W-1:0]     in_vec_s, prev_in_r;
  logic                pending_r;
  logic                change_s;
  logic                refresh_hit_s;
  logic                period_end_s;
  logic                led_active_s;
  logic [6:0]          hex_pat_s [DIGITS];

  for (genvar g = 0; g < DIGITS; g++) begin : g_hex
    disp_hex2seg u_hex2seg (
      .nibble  (data_text[4*g +: 4]),
      .pattern (hex_pat_s[g])
    );
  end

  // per-digit byte selection; digit 7 lands in the top byte so it leaves the chain first
  always_comb begin
    seg_img_s = {SEG_BITS{1'b1}};
    for (int i = 0; i < DIGITS; i++) begin
      if (!en[i]) begin
        seg_img_s[8*i +: 8] = 8'hFF;
      end else if (mode) begin
        seg_img_s[8*i +: 8] = data_graphic[8*i +: 8];
      end else begin
        seg_img_s[8*i +: 8] = {~dot[i], hex_pat_s[i]};
      end
    end
  end

  assign in_vec_s     = {en, mode, data_text, data_graphic, dot, led};
  assign change_s     = (in_vec_s != prev_in_r);
  assign period_end_s = (phase_r == PH_W'(PERIOD - 1));
  assign led_active_s = (bit_r < BIT_W'(LED_BITS));

`ifdef DISP_AUTO_REFRESH_EN
  localparam int REFRESH_CYC = CLK_FREQ * REFRESH_MS * 1000;
  logic [31:0] refresh_cnt_r;

  assign refresh_hit_s = (refresh_cnt_r == 32'(REFRESH_CYC - 1));

  // refresh timer, restarted by every frame load so steady inputs repeat at a fixed rate
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt_r <= 32'd0;
    end else if ((state_r == ST_LOAD) || refresh_hit_s) begin
      refresh_cnt_r <= 32'd0;
    end else begin
      refresh_cnt_r <= refresh_cnt_r + 32'd1;
    end
  end
`else
  assign refresh_hit_s = 1'b0;
`endif

  // frame sequencing: clear, wait, load, 64 bit periods, latch
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    bit_nxt_s   = bit_r;
    case (state_r)
      ST_CLEAR: begin
        if (period_end_s) begin
          state_nxt_s = ST_LOAD;
          phase_nxt_s = '0;
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_IDLE: begin
        // a change seen this cycle goes straight to LOAD, which snapshots it
        if (pending_r || change_s || refresh_hit_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_nxt_s = ST_SHIFT;
        phase_nxt_s = '0;
        bit_nxt_s   = '0;
      end
      ST_SHIFT: begin
        if (period_end_s) begin
          phase_nxt_s = '0;
          if (bit_r == BIT_W'(SEG_BITS - 1)) begin
            state_nxt_s = ST_LATCH;
            bit_nxt_s   = '0;
          end else begin
            bit_nxt_s = bit_r + BIT_W'(1);
          end
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      ST_LATCH: begin
        if (period_end_s) begin
          state_nxt_s = ST_IDLE;
          phase_nxt_s = '0;
        end else begin
          phase_nxt_s = phase_r + PH_W'(1);
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        phase_nxt_s = '0;
        bit_nxt_s   = '0;
      end
    endcase
  end

  // state, counters, change detector and frame shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_CLEAR;
      phase_r   <= '0;
      bit_r     <= '0;
      seg_sh_r  <= '0;
      led_sh_r  <= '0;
      pending_r <= 1'b0;
      prev_in_r <= in_vec_s;
    end else begin
      state_r   <= state_nxt_s;
      phase_r   <= phase_nxt_s;
      bit_r     <= bit_nxt_s;
      prev_in_r <= in_vec_s;
      if (state_r == ST_LOAD) begin
        pending_r <= 1'b0;
      end else if (change_s || refresh_hit_s) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
      if (state_r == ST_LOAD) begin
        seg_sh_r <= seg_img_s;
        led_sh_r <= ~led;
      end else if ((state_r == ST_SHIFT) && period_end_s) begin
        seg_sh_r <= {seg_sh_r[SEG_BITS-2:0], 1'b1};
        led_sh_r <= {led_sh_r[LED_BITS-2:0], 1'b1};
      end else begin
        seg_sh_r <= seg_sh_r;
        led_sh_r <= led_sh_r;
      end
    end
  end

  // board pins, decoded from the frame position one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      led_clk   <= 1'b0;
      seg_clk   <= 1'b0;
      led_do    <= 1'b0;
      seg_do    <= 1'b0;
      led_en    <= 1'b0;
      seg_en    <= 1'b0;
      led_clr_n <= 1'b0;
      seg_clr_n <= 1'b0;
    end else begin
      seg_clr_n <= (state_r != ST_CLEAR);
      led_clr_n <= (state_r != ST_CLEAR);
      seg_en    <= (state_r == ST_LATCH);
      led_en    <= (state_r == ST_LATCH);
      seg_clk   <= (state_r == ST_SHIFT) && (phase_r >= PH_W'(HALF));
      led_clk   <= (state_r == ST_SHIFT) && (phase_r >= PH_W'(HALF)) && led_active_s;
      if (state_r == ST_SHIFT) begin
        seg_do <= seg_sh_r[SEG_BITS-1];
      end else begin
        seg_do <= seg_do;
      end
      // the LED chain is only 16 deep; its data line freezes once those bits are out
      if ((state_r == ST_SHIFT) && led_active_s) begin
        led_do <= led_sh_r[LED_BITS-1];
      end else begin
        led_do <= led_do;
      end
    end
  end

endmodule

// File: tb/tb_board_disp_shift_sword.sv
// Table-driven bench for board_disp_shift_sword: decodes the serial chains back into
// frames and compares them with hand-computed images, plus reset/mid-frame/refresh sequences.
module tb_board_disp_shift_sword;

  localparam int CLK_FREQ    = 4;
  localparam int SHIFT_FREQ  = 1;
  localparam int REFRESH_MS  = 1;
  localparam int HALF        = CLK_FREQ / (2 * SHIFT_FREQ);
  localparam int FRAME_GAP   = 130 * HALF + 2;
  localparam int MAX_LAT     = 2 + 128 * HALF;
  localparam int REFRESH_CYC = CLK_FREQ * REFRESH_MS * 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  en;
  logic        mode;
  logic [31:0] data_text;
  logic [63:0] data_graphic;
  logic [7:0]  dot;
  logic [15:0] led;
  logic        led_clk, seg_clk, led_do, seg_do, led_en, seg_en, led_clr_n, seg_clr_n;

  board_disp_shift_sword #(
    .CLK_FREQ(CLK_FREQ), .SHIFT_FREQ(SHIFT_FREQ), .REFRESH_MS(REFRESH_MS)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .data_text(data_text),
    .data_graphic(data_graphic), .dot(dot), .led(led),
    .led_clk(led_clk), .seg_clk(seg_clk), .led_do(led_do), .seg_do(seg_do),
    .led_en(led_en), .seg_en(seg_en), .led_clr_n(led_clr_n), .seg_clr_n(seg_clr_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // chain decoder state, updated away from the active edge
  logic [63:0] cap_seg = 64'd0, frame_seg = 64'd0;
  logic [15:0] cap_led = 16'd0, frame_led = 16'd0;
  logic        frame_led_do = 1'b0;
  logic        prev_seg_clk = 1'b0, prev_led_clk = 1'b0, prev_en = 1'b0;
  int seg_n = 0, led_n = 0, frame_seg_n = 0, frame_led_n = 0;
  int en_width = 0, frame_en_width = 0, en_pulses = 0, pair_err = 0;
  int cyc = 0, en_rise_last = 0, en_rise_prev = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      seg_n = 0;
      led_n = 0;
    end else begin
      if (seg_clk && !prev_seg_clk) begin
        cap_seg = {cap_seg[62:0], seg_do};
        seg_n++;
      end
      if (led_clk && !prev_led_clk) begin
        cap_led = {cap_led[14:0], led_do};
        led_n++;
      end
    end
    if (seg_en && !prev_en) begin
      frame_seg = cap_seg;  frame_seg_n = seg_n;
      frame_led = cap_led;  frame_led_n = led_n;
      frame_led_do = led_do;
      seg_n = 0;  led_n = 0;  en_width = 0;
      en_rise_prev = en_rise_last;
      en_rise_last = cyc;
    end
    if (seg_en) en_width++;
    if (!seg_en && prev_en) begin
      en_pulses++;
      frame_en_width = en_width;
    end
    if ((seg_en !== led_en) || (seg_clr_n !== led_clr_n)) pair_err++;
    prev_seg_clk = seg_clk;
    prev_led_clk = led_clk;
    prev_en      = seg_en;
  end

  task automatic wait_frame(input int budget, output bit seen);
    int start;
    start = en_pulses;
    seen  = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (en_pulses != start) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_frame(input string name, input logic [63:0] exp_seg, input logic [15:0] exp_led);
    bit seen;
    wait_frame(700, seen);
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no latch pulse expected one within 700 cycles", name);
    end
    check({name, "_seg"},    frame_seg, exp_seg);
    check({name, "_seg_n"},  64'(frame_seg_n), 64'd64);
    check({name, "_led"},    64'(frame_led), 64'(exp_led));
    check({name, "_led_n"},  64'(frame_led_n), 64'd16);
    check({name, "_led_hold"}, 64'(frame_led_do), 64'(exp_led[0]));
    check({name, "_en_w"},   64'(frame_en_width), 64'(2 * HALF));
  endtask

  task automatic wait_bits(input string name, input int nbits);
    int i;
    for (i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (seg_n >= nbits) break;
    end
    checks++;
    if (i >= 700) begin
      failures++;
      $display("FAIL %s: got %0d shifted bits expected %0d", name, seg_n, nbits);
    end
  endtask

  typedef struct {
    logic        mode;
    logic [7:0]  en;
    logic [31:0] text;
    logic [63:0] graphic;
    logic [7:0]  dot;
    logic [15:0] led;
    logic [63:0] exp_seg;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: got no end of test expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int base;
    bit seen;

    vecs[0] = '{1'b0, 8'hFF, 32'h0123_4567, 64'h0, 8'h00, 16'h0000, 64'hC0F9A4B0_999282F8, 16'hFFFF};
    vecs[1] = '{1'b0, 8'hFF, 32'h89AB_CDEF, 64'h0, 8'h00, 16'hFFFF, 64'h80908883_C6A1868E, 16'h0000};
    vecs[2] = '{1'b0, 8'hFF, 32'h0000_0000, 64'h0, 8'hA5, 16'h1234, 64'h40C040C0_C040C040, 16'hEDCB};
    vecs[3] = '{1'b0, 8'h0F, 32'hFFFF_FFFF, 64'h0, 8'hFF, 16'h00FF, 64'hFFFFFFFF_0E0E0E0E, 16'hFF00};
    vecs[4] = '{1'b1, 8'hFF, 32'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 16'hA5A5, 64'h01234567_89ABCDEF, 16'h5A5A};
    vecs[5] = '{1'b1, 8'h00, 32'h0, 64'h0123_4567_89AB_CDEF, 8'hFF, 16'h8001, 64'hFFFFFFFF_FFFFFFFF, 16'h7FFE};
    vecs[6] = '{1'b0, 8'h00, 32'h1234_5678, 64'h0, 8'h00, 16'h0000, 64'hFFFFFFFF_FFFFFFFF, 16'hFFFF};
    vecs[7] = '{1'b1, 8'h81, 32'h0, 64'h1122_3344_5566_7788, 8'h00, 16'h0F0F, 64'h11FFFFFF_FFFFFF88, 16'hF0F0};

    rst = 1'b1; mode = 1'b0; en = 8'h01; data_text = 32'h1;
    data_graphic = 64'h0; dot = 8'h00; led = 16'h8001;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 64'({led_clk, seg_clk, led_do, seg_do, led_en, seg_en, led_clr_n, seg_clr_n}), 64'h0);

    @(negedge clk) rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (seg_clr_n == 1'b0) cnt++;
      else break;
    end
    check("clear_len", 64'(cnt), 64'(2 * HALF));
    check_frame("first", 64'hFFFFFFFF_FFFFFFF9, 16'h7FFE);

    base = en_pulses;
    repeat (300) @(posedge clk);
    #1;
    check("no_extra_after_first", 64'(en_pulses), 64'(base));

    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      mode = vecs[v].mode; en = vecs[v].en; data_text = vecs[v].text;
      data_graphic = vecs[v].graphic; dot = vecs[v].dot; led = vecs[v].led;
      check_frame($sformatf("vec%0d", v), vecs[v].exp_seg, vecs[v].exp_led);
      repeat (2) @(posedge clk);
    end

    // change in IDLE to start of latch
    @(negedge clk) led = 16'h0001;
    @(posedge clk);
    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      cnt++;
      if (seg_en) break;
    end
    checks++;
    if ((cnt > MAX_LAT) || (cnt < 128 * HALF)) begin
      failures++;
      $display("FAIL latency: got %0d cycles expected at most %0d", cnt, MAX_LAT);
    end
    check_frame("latency_frame", 64'h11FFFFFF_FFFFFF88, 16'hFFFE);

    // input change while a frame is in flight
    @(negedge clk) led = 16'h00F0;
    wait_bits("mid_reach_bit30", 30);
    @(negedge clk) led = 16'h0F00;
    check_frame("mid_old", 64'h11FFFFFF_FFFFFF88, 16'hFF0F);
    base = en_rise_last;
    check_frame("mid_new", 64'h11FFFFFF_FFFFFF88, 16'hF0FF);
    check("mid_gap", 64'(en_rise_last - base), 64'(FRAME_GAP));
    base = en_pulses;
    repeat (600) @(posedge clk);
    #1;
    check("mid_no_third", 64'(en_pulses), 64'(base));

    // reset in the middle of a frame
    @(negedge clk) led = 16'h3C3C;
    wait_bits("rst_reach_bit40", 40);
    base = en_pulses;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", 64'({led_clk, seg_clk, led_do, seg_do, led_en, seg_en, led_clr_n, seg_clr_n}), 64'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check_frame("post_reset", 64'h11FFFFFF_FFFFFF88, 16'hC3C3);
    check("post_reset_one_pulse", 64'(en_pulses - base), 64'd1);

    // steady inputs over five refresh intervals
    base = en_pulses;
    repeat (5 * REFRESH_CYC) @(posedge clk);
    #1;
`ifdef DISP_AUTO_REFRESH_EN
    checks++;
    if ((en_pulses - base) < 4) begin
      failures++;
      $display("FAIL refresh_count: got %0d frames expected at least 4", en_pulses - base);
    end
    checks++;
    if (((en_rise_last - en_rise_prev) < REFRESH_CYC - 2) || ((en_rise_last - en_rise_prev) > REFRESH_CYC + 4)) begin
      failures++;
      $display("FAIL refresh_period: got %0d cycles expected about %0d", en_rise_last - en_rise_prev, REFRESH_CYC);
    end
`else
    check("no_refresh", 64'(en_pulses), 64'(base));
`endif
    check("clr_n_held", 64'({led_clr_n, seg_clr_n}), 64'h3);
    check("chain_pairing", 64'(pair_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_disp_shift_sword.md
# board_disp_shift_sword

Serial display driver that turns the board register image (LED word, 7-segment text/graphic data, digit enables, dots) into bit streams for the SWORD board's LED and 7-segment shift-register chains. It sits directly downstream of the board wishbone register block, takes its `led`/`en`/`mode`/`data`/`dot` outputs, and drives the `led_*`/`seg_*` board pins. Frames are sent when the inputs change, and optionally on a periodic refresh timer.

## Interface
- `CLK_FREQ`, default 100: main clock frequency in MHz.
- `SHIFT_FREQ`, default 1: shift clock frequency in MHz. `HALF = CLK_FREQ/(2*SHIFT_FREQ)` must be at least 1.
- `REFRESH_MS`, default 10: periodic refresh interval in ms. Only used with `DISP_AUTO_REFRESH_EN`.
- `clk` input, 1 bit: main clock. One clock domain.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 8 bits: digit enable; bit i controls digit i, where digit 0 is the rightmost.
- `mode` input, 1 bit: 0 = text (hex decode), 1 = graphic (raw segments).
- `data_text` input, 32 bits: eight hex nibbles; nibble i goes to digit i.
- `data_graphic` input, 64 bits: raw active-low segments; byte i goes to digit i.
- `dot` input, 8 bits: decimal point per digit, active-high. Text mode only.
- `led` input, 16 bits: LED states, active-high.
- `led_clk`, `seg_clk` output, 1 bit each: shift clocks.
- `led_do`, `seg_do` output, 1 bit each: serial data.
- `led_en`, `seg_en` output, 1 bit each: latch strobes.
- `led_clr_n`, `seg_clr_n` output, 1 bit each: chain clear, active-low.

## Operation
- **Segment byte format.** Each byte is `{dp,g,f,e,d,c,b,a}`, active-low.
- **Text mode.** Digit byte = `{~dot[i], hex2seg(nibble i)}`.
- **Graphic mode.** Digit byte = `data_graphic[8i+7:8i]`; `dot` is ignored.
- **Disabled digits.** Any digit with `en[i]=0` sends `8'hFF` (blank), in both modes.
- **Segment stream.** 64 bits: digit 7 first, MSB first within each byte.
- **LED stream.** 16 bits of `~led`, `led[15]` first.
- **States:**
  - CLEAR: after reset.
  - IDLE.
  - LOAD: 1 cycle; snapshots all inputs into 64+16-bit shift registers.
  - SHIFT: 64 bit periods.
  - LATCH: 1 bit period.
- **Transitions:**
  - CLEAR→LOAD.
  - IDLE→LOAD when `pending` is set.
  - LOAD→SHIFT.
  - SHIFT→LATCH after bit 63.
  - LATCH→IDLE.
- **`pending` flag.**
  - Set when any input differs from its value one cycle earlier.
  - Set on refresh-timer expiry.
  - Cleared in LOAD.
  - Input changes during SHIFT/LATCH set `pending`, so exactly one further frame follows; the frame in flight is not disturbed.
  - If a change and LOAD occur in the same cycle, LOAD clears `pending` and the changed value is snapshotted.
- **Channel activity.** The LED channel is active only for bits 0..15. For bits 16..63, `led_clk` stays 0 and `led_do` holds its last value. Both channels latch together in LATCH.

## Timing
- **Reset values.** While `rst` is high, all outputs are 0, including both `clr_n`. Reset mid-frame aborts immediately to CLEAR.
- **CLEAR.** Lasts `2*HALF` cycles after `rst` falls, with `clr_n=0`. Then `clr_n=1` permanently until the next reset.
- **Bit period.** `2*HALF` cycles. `*_do` changes on the first cycle of the period with `*_clk=0`. `*_clk` is 1 for the last `HALF` cycles, so the chain samples on the rising edge with `HALF` cycles of setup.
- **LATCH.** `*_en=1` for the full `2*HALF` cycles; `*_clk=0`.
- **Frame length.** `1 + 65*2*HALF` cycles (LOAD + 64 bits + latch). This is 6501 cycles at the defaults.
- **Input to latch latency.** From an input change in IDLE to the start of `*_en`, latency is at most `2 + 64*2*HALF` cycles.
- **First frame.** The first frame after reset starts immediately after CLEAR, with no input change needed.

## Configuration
- **`DISP_AUTO_REFRESH_EN` defined.** A counter of `CLK_FREQ*REFRESH_MS*1000` cycles sets `pending` on expiry. It restarts at LOAD, so steady inputs are resent every `REFRESH_MS`.
- **Not defined.** The counter is absent. After the post-reset frame, frames are sent only on input change.

## Structure
- **Shared package `disp_sword_pkg`:**
  - hex-to-segment pattern constants, `0`=`8'hC0` … `F`=`8'h8E` without dp;
  - `SEG_BITS=64`, `LED_BITS=16`;
  - state encoding.
- **Sub-module `disp_hex2seg`:** combinational nibble → 7-bit active-low pattern, instantiated 8×.
- **In the top:** frame FSM, bit and phase counters, shift registers, change detector, optional refresh counter.

## Test plan
- **Reset and first frame.** Reset with `HALF=2`, `mode=0`, `en=8'h01`, `data_text=32'h1`, `dot=0`, `led=16'h8001` → `clr_n` low 4 cycles after reset. `seg_do` samples on `seg_clk` rising edges = 56 ones then `8'hF9`. `led_do` = 0, then fourteen 1s, then 0. One `*_en` pulse 4 cycles wide.
- **Graphic mode.** `mode=1`, `data_graphic=64'h0123_4567_89AB_CDEF`, `en=8'hFF`, `dot=8'hFF` → sampled stream equals `data_graphic` MSB first; dot has no effect.
- **Digit enable.** `en=8'h00` in any mode → 64 ones on `seg_do`.
- **Change mid-frame.** Change `led` at bit 30 → the current frame completes unchanged, then exactly one further frame carries the new value.
- **Reset mid-frame.** Assert `rst` at bit 40 → all outputs 0 on the next cycle. A full frame follows after release.
- **Refresh macro.** With steady inputs and `REFRESH_MS=1` (`CLK_FREQ` reduced in the bench): with `DISP_AUTO_REFRESH_EN`, frames repeat every 1 ms; without it, no second frame within 5 ms.
